// File: rtl/instr_trip_scan_ctrl.sv
// Trip scan sequencer: captures a sample vector, evaluates one channel per cycle
// against snapshotted setpoints/modes, then debounces and latches per-channel trips.
module instr_trip_scan_ctrl #(
  parameter int unsigned NChannels = 3,
  parameter int unsigned Width     = 32,
  parameter int unsigned Debounce  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [NChannels*Width-1:0] sample_vals,
  input  logic                       cfg_sp_wr,
  input  logic                       cfg_mode_wr,
  input  logic [1:0]                 cfg_ch,
  input  logic [Width-1:0]           cfg_sp,
  input  logic [1:0]                 cfg_mode,
  input  logic                       trip_reset,
  output logic [NChannels-1:0]       trip_out,
  output logic                       scan_done,
  output logic                       busy
);

  localparam int unsigned IdxW = (NChannels > 1) ? $clog2(NChannels) : 1;
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] DebLim  = CntW'(Debounce);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChannels - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    UPDATE
  } state_t;

  state_t state;

  logic [NChannels-1:0][Width-1:0] sp_live;
  logic [NChannels-1:0][1:0]       mode_live;
  logic [NChannels-1:0][Width-1:0] val_sh;
  logic [NChannels-1:0][Width-1:0] sp_sh;
  logic [NChannels-1:0][1:0]       mode_sh;
  logic [NChannels-1:0][CntW-1:0]  cnt;
  logic [NChannels-1:0][CntW-1:0]  upd_cnt;
  logic [NChannels-1:0]            upd_trip;
  logic [NChannels-1:0]            idle_clr;
  logic [NChannels-1:0]            raw_scan;
  logic [NChannels-1:0]            last_raw;
  logic [IdxW-1:0]                 idx;

  logic [Width-1:0] cur_val;
  logic [Width-1:0] cur_sp;
  logic [1:0]       cur_mode;
  logic             cur_sens;
  logic             cur_raw;

  assign sample_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  // Live configuration registers; a running scan only sees its snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_live   <= '0;
      mode_live <= '0;
    end else begin
      if (cfg_sp_wr && (32'(cfg_ch) < NChannels))
        sp_live[cfg_ch] <= cfg_sp;
      if (cfg_mode_wr && (32'(cfg_ch) < NChannels))
        mode_live[cfg_ch] <= cfg_mode;
    end
  end

  // Per-cycle channel evaluation from the shadow copies.
  always_comb begin
    cur_val  = '0;
    cur_sp   = '0;
    cur_mode = '0;
    for (int unsigned i = 0; i < NChannels; i++) begin
      if (idx == IdxW'(i)) begin
        cur_val  = val_sh[i];
        cur_sp   = sp_sh[i];
        cur_mode = mode_sh[i];
      end
    end
    if (idx == '0)
      cur_sens = $signed(cur_val) < $signed(cur_sp);
    else
      cur_sens = cur_val > cur_sp;
    cur_raw = (cur_mode == 2'd2) || ((cur_mode == 2'd1) && cur_sens);
  end

  // Debounce/latch update, with a coincident trip_reset applied after the latch.
  always_comb begin
    upd_cnt  = '0;
    upd_trip = '0;
    idle_clr = '0;
    for (int unsigned i = 0; i < NChannels; i++) begin
      if (raw_scan[i])
        upd_cnt[i] = (cnt[i] >= DebLim) ? DebLim : cnt[i] + CntW'(1);
      else
        upd_cnt[i] = '0;
      upd_trip[i] = trip_out[i] | (upd_cnt[i] == DebLim);
      if (trip_reset && !raw_scan[i]) begin
        upd_cnt[i]  = '0;
        upd_trip[i] = 1'b0;
      end
      idle_clr[i] = trip_reset && !last_raw[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      val_sh    <= '0;
      sp_sh     <= '0;
      mode_sh   <= '0;
      raw_scan  <= '0;
      last_raw  <= '0;
      cnt       <= '0;
      trip_out  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          trip_out <= trip_out & ~idle_clr;
          for (int unsigned i = 0; i < NChannels; i++)
            if (idle_clr[i]) cnt[i] <= '0;
          if (sample_valid) begin
            val_sh  <= sample_vals;
            sp_sh   <= sp_live;
            mode_sh <= mode_live;
            idx     <= '0;
            state   <= EVAL;
          end
        end
        EVAL: begin
          trip_out <= trip_out & ~idle_clr;
          for (int unsigned i = 0; i < NChannels; i++)
            if (idle_clr[i]) cnt[i] <= '0;
          raw_scan[idx] <= cur_raw;
          if (idx == LastIdx)
            state <= UPDATE;
          else
            idx <= idx + IdxW'(1);
        end
        UPDATE: begin
          cnt       <= upd_cnt;
          trip_out  <= upd_trip;
          last_raw  <= raw_scan;
          scan_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
